// File: rtl/rc4_pkg.sv
// Shared constants and types for the RC4 decrypt path: memory handler selects,
// the plaintext alphabet bounds and the result-reader state encoding.
package rc4_pkg;

   localparam logic [1:0] MEM_SEL_NONE = 2'd0;
   localparam logic [1:0] MEM_SEL_S    = 2'd1;
   localparam logic [1:0] MEM_SEL_ENC  = 2'd2;
   localparam logic [1:0] MEM_SEL_DEC  = 2'd3;

   localparam logic [7:0] CHAR_SPACE = 8'd32;
   localparam logic [7:0] CHAR_LO    = 8'd97;
   localparam logic [7:0] CHAR_HI    = 8'd122;

   typedef enum logic [2:0] {
      RD_IDLE   = 3'd0,
      RD_SETUP  = 3'd1,
      RD_READ   = 3'd2,
      RD_SAMPLE = 3'd3,
      RD_CHECK  = 3'd4,
      RD_SEND   = 3'd5,
      RD_NEXT   = 3'd6,
      RD_DONE   = 3'd7
   } reader_state_e;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext alphabet test: lower-case letters or space.
// Shared with the decrypt cores so every block agrees on what "readable" means.
module rc4_char_check
   import rc4_pkg::*;
(
   input  logic [7:0] char_in,
   output logic       is_valid
);

   logic is_space;
   logic is_lower;

   assign is_space = (char_in == CHAR_SPACE);
   assign is_lower = (char_in >= CHAR_LO) && (char_in <= CHAR_HI);
   assign is_valid = is_space || is_lower;

endmodule

// File: rtl/decrypt_result_reader.sv
// Reads the decrypted-output RAM back through the memory handler, checks each
// byte against the plaintext alphabet and streams it out on a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETUP  | own the memory handler, present address k
// READ   | RAM access in flight (address held)
// SAMPLE | q_data valid, capture into char_out
// CHECK  | grade the byte, raise char_valid
// SEND   | hold char_out until char_ready
// NEXT   | finish on last byte or abort, else advance k
// DONE   | result held until the next start
module decrypt_result_reader
   import rc4_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  msg_last,
   input  logic              abort,
   input  logic [7:0]        q_data,
   output logic              mem_req,
   output logic [1:0]        memory_sel,
   output logic [ADDR_W-1:0] address,
   output logic [7:0]        char_out,
   output logic              char_valid,
   input  logic              char_ready,
   output logic              done,
   output logic              msg_ok,
   output logic [LEN_W-1:0]  bad_index
);

   reader_state_e    state;
   reader_state_e    state_nxt;
   logic [LEN_W-1:0] k;
   logic [LEN_W-1:0] len;
   logic             byte_ok;
   logic             start_ok;
   logic             finish_now;

   rc4_char_check u_char_check (
      .char_in  (char_out),
      .is_valid (byte_ok)
   );

   assign start_ok   = start && ((state == RD_IDLE) || (state == RD_DONE));
   // Comparing against len (not a wrapped k) lets msg_last = all-ones read every byte once.
   assign finish_now = (k == len) || abort;

   always_comb begin
      state_nxt = state;
      case (state)
         RD_IDLE:   if (start_ok) state_nxt = RD_SETUP;
         RD_SETUP:  state_nxt = RD_READ;
         RD_READ:   state_nxt = RD_SAMPLE;
         RD_SAMPLE: state_nxt = RD_CHECK;
         RD_CHECK:  state_nxt = RD_SEND;
         RD_SEND:   if (char_ready) state_nxt = RD_NEXT;
         RD_NEXT:   state_nxt = finish_now ? RD_DONE : RD_SETUP;
         RD_DONE:   if (start_ok) state_nxt = RD_SETUP;
         default:   state_nxt = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RD_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         k          <= '0;
         len        <= '0;
         char_out   <= '0;
         char_valid <= 1'b0;
         done       <= 1'b0;
         msg_ok     <= 1'b0;
         bad_index  <= '0;
      end else if (start_ok) begin
         len       <= msg_last;
         k         <= '0;
         msg_ok    <= 1'b1;
         done      <= 1'b0;
         bad_index <= '0;
      end else begin
         case (state)
            RD_SAMPLE: char_out <= q_data;
            RD_CHECK: begin
               // Only the first offending byte is recorded.
               if (!byte_ok && msg_ok) begin
                  msg_ok    <= 1'b0;
                  bad_index <= k;
               end
               char_valid <= 1'b1;
            end
            RD_SEND: begin
               if (char_ready) char_valid <= 1'b0;
            end
            RD_NEXT: begin
               if (finish_now) done <= 1'b1;
               else            k    <= k + LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   // The handler is owned from SETUP through NEXT; address stays k for the whole byte.
   assign mem_req    = (state != RD_IDLE) && (state != RD_DONE);
   assign memory_sel = mem_req ? MEM_SEL_DEC : MEM_SEL_NONE;
   assign address    = mem_req ? ADDR_W'(k) : '0;

endmodule

// File: tb/tb_decrypt_result_reader.sv
// Scoreboard bench for decrypt_result_reader with a 2-cycle-latency RAM model.
module tb_decrypt_result_reader;
   import rc4_pkg::*;

   localparam int ADDR_W = 8;
   localparam int LEN_W  = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              abort = 1'b0;
   logic              char_ready = 1'b0;
   logic [LEN_W-1:0]  msg_last = '0;
   logic [7:0]        q_data = 8'h00;
   logic [7:0]        q_pipe = 8'h00;
   logic              mem_req;
   logic [1:0]        memory_sel;
   logic [ADDR_W-1:0] address;
   logic [7:0]        char_out;
   logic              char_valid;
   logic              done;
   logic              msg_ok;
   logic [LEN_W-1:0]  bad_index;

   logic [7:0] mem [0:255];

   typedef struct packed {
      logic [4:0] idx;
      logic [7:0] data;
   } exp_t;
   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;
   int hs_count = 0;
   logic       prev_valid = 1'b0;
   logic       prev_hs = 1'b0;
   logic [7:0] prev_char = 8'h00;

   decrypt_result_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .msg_last   (msg_last),
      .abort      (abort),
      .q_data     (q_data),
      .mem_req    (mem_req),
      .memory_sel (memory_sel),
      .address    (address),
      .char_out   (char_out),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .done       (done),
      .msg_ok     (msg_ok),
      .bad_index  (bad_index)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      q_pipe <= (memory_sel == 2'd3) ? mem[address] : 8'hEE;
      q_data <= q_pipe;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push(input int idx, input logic [7:0] d);
      exp_t e;
      e.idx  = idx[4:0];
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int last);
      start    = 1'b1;
      msg_last = last[LEN_W-1:0];
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int i = 0;
      while (!done && i < budget) begin
         tick();
         i++;
      end
      check(name, done, 1);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_char_valid"}, char_valid, 0);
      check({name, "_char_out"}, char_out, 0);
      check({name, "_done"}, done, 0);
      check({name, "_msg_ok"}, msg_ok, 0);
      check({name, "_mem_req"}, mem_req, 0);
      check({name, "_sel_addr_bad"}, {memory_sel, address, bad_index}, 0);
   endtask

   // Monitor: pops the scoreboard on every handshake and enforces hold-until-accepted.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         if (prev_valid && !prev_hs) begin
            check("hold_valid", char_valid, 1);
            check("hold_char", char_out, prev_char);
         end
         if (char_valid && char_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_char actual=%0h addr=%0h required=none", char_out, address);
            end else begin
               e = sb.pop_front();
               check("char_data", char_out, e.data);
               check("char_addr", address, {3'b000, e.idx});
            end
         end
         prev_valid = char_valid;
         prev_hs    = char_valid && char_ready;
         prev_char  = char_out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      string s;
      int    lat;
      int    hs0;
      int    n;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      #1;
      check_idle_outputs("reset");
      tick(); tick();
      reset = 1'b1;
      tick();

      // 1: full message, ready tied high, first-valid latency
      s = "the secret message is here";
      for (int i = 0; i < 26; i++) begin
         mem[i] = s[i];
         push(i, s[i]);
      end
      char_ready = 1'b1;
      hs0 = hs_count;
      start = 1'b1;
      msg_last = 5'd25;
      lat = 0;
      while (!char_valid && lat < 20) begin
         tick();
         start = 1'b0;
         lat++;
      end
      check("first_valid_latency", lat, 5);
      wait_done(400, "t1_done");
      tick();
      check("t1_msg_ok", msg_ok, 1);
      check("t1_mem_req", mem_req, 0);
      check("t1_sel_addr", {memory_sel, address}, 0);
      check("t1_count", hs_count - hs0, 26);
      check("t1_sb_empty", sb.size(), 0);

      // 2: 32 bytes, two bad bytes, first one reported
      for (int i = 0; i < 32; i++) begin
         mem[i] = 8'h61 + 8'(i % 26);
         if (i == 3) mem[i] = 8'h7B;
         if (i == 9) mem[i] = 8'h41;
         push(i, mem[i]);
      end
      hs0 = hs_count;
      do_start(31);
      wait_done(400, "t2_done");
      check("t2_msg_ok", msg_ok, 0);
      check("t2_bad_index", bad_index, 3);
      check("t2_count", hs_count - hs0, 32);

      // 3: stall byte 0 for 7 cycles
      mem[0] = "k"; mem[1] = " "; mem[2] = "z";
      push(0, "k"); push(1, " "); push(2, "z");
      char_ready = 1'b0;
      do_start(2);
      n = 0;
      while (!char_valid && n < 20) begin
         tick();
         n++;
      end
      check("t3_valid_seen", char_valid, 1);
      repeat (7) begin
         @(negedge clk);
         check("t3_stall_valid", char_valid, 1);
         check("t3_stall_char", char_out, 8'h6B);
         check("t3_stall_addr", address, 0);
      end
      @(posedge clk); #1;
      char_ready = 1'b1;
      wait_done(100, "t3_done");
      check("t3_msg_ok", msg_ok, 1);

      // 4: abort while byte 4 is in SEND
      for (int i = 0; i < 10; i++) mem[i] = 8'h61 + 8'(i);
      for (int i = 0; i < 5; i++) push(i, 8'h61 + 8'(i));
      hs0 = hs_count;
      do_start(9);
      n = 0;
      while (!(char_valid && address == 8'd4) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t4_reached_byte4", {char_valid, address}, {1'b1, 8'd4});
      abort = 1'b1;
      n = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (!done) n++;
      end
      check("t4_done_within_2", done, 1);
      abort = 1'b0;
      tick(); tick();
      check("t4_count", hs_count - hs0, 5);
      check("t4_msg_ok", msg_ok, 1);
      check("t4_mem_req", mem_req, 0);

      // 5: single byte, then restart from DONE
      mem[0] = "q"; mem[1] = "w";
      push(0, "q");
      hs0 = hs_count;
      do_start(0);
      check("t5_done_cleared", done, 0);
      wait_done(50, "t5_done_a");
      check("t5_count_a", hs_count - hs0, 1);
      push(0, "q");
      do_start(0);
      wait_done(50, "t5_done_b");
      tick();
      check("t5_count_b", hs_count - hs0, 2);
      check("t5_msg_ok", msg_ok, 1);

      // 6: async reset during READ of byte 2, then restart
      s = "again!";
      for (int i = 0; i < 6; i++) mem[i] = s[i];
      push(0, "a"); push(1, "g");
      do_start(5);
      n = 0;
      while (!(mem_req && address == 8'd2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("t6_in_read", {mem_req, address}, {1'b1, 8'd2});
      reset = 1'b0;
      #1;
      check_idle_outputs("t6_reset");
      check("t6_sb_empty", sb.size(), 0);
      tick();
      reset = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) push(i, s[i]);
      hs0 = hs_count;
      do_start(5);
      wait_done(200, "t6_done");
      check("t6_count", hs_count - hs0, 6);
      check("t6_msg_ok", msg_ok, 0);
      check("t6_bad_index", bad_index, 5);

      tick();
      check("final_sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
